hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage RV32I core. It is the stall/flush side of the forwarding path: it handles the hazards that forwarding cannot resolve.
- Covers three cases: load-use dependency, taken branch/jump resolved in EX, and multi-cycle data-memory access in MEM.
- Drives the stall/flush controls of PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Keeps a memory-wait state machine, a timeout watchdog and saturating performance counters.

---
 rtl/hazard_ctrl_if.sv | 44 ++++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_ctrl.
// The slave side is the controller and the master side is the pipeline.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_RF_rs1;
  logic [4:0]       ID_RF_rs2;
  logic             ID_use_rs1;
  logic             ID_use_rs2;
  logic             EX_MemRead;
  logic [4:0]       EX_RF_rd;
  logic             EX_PCSrc;
  logic             MEM_req;
  logic             mem_ready;

  logic             PC_stall;
  logic             IFID_stall;
  logic             IFID_flush;
  logic             IDEX_stall;
  logic             IDEX_flush;
  logic             EXMEM_stall;
  logic             MEMWB_flush;
  logic             mem_wait;
  logic             mem_err;
  logic [CNT_W-1:0] lu_cnt;
  logic [CNT_W-1:0] fl_cnt;
  logic [CNT_W-1:0] mw_cnt;

  modport master (
    output ID_RF_rs1, ID_RF_rs2, ID_use_rs1, ID_use_rs2,
           EX_MemRead, EX_RF_rd, EX_PCSrc, MEM_req, mem_ready,
    input  PC_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush,
           EXMEM_stall, MEMWB_flush, mem_wait, mem_err,
           lu_cnt, fl_cnt, mw_cnt
  );

  modport slave (
    input  ID_RF_rs1, ID_RF_rs2, ID_use_rs1, ID_use_rs2,
           EX_MemRead, EX_RF_rd, EX_PCSrc, MEM_req, mem_ready,
    output PC_stall, IFID_stall, IFID_flush, IDEX_stall, IDEX_flush,
           EXMEM_stall, MEMWB_flush, mem_wait, mem_err,
           lu_cnt, fl_cnt, mw_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: load-use, EX-resolved
// control transfer and multi-cycle data-memory wait, with watchdog and counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int WAIT_W = $clog2(TIMEOUT);

  typedef enum logic {RUN, MEM_WAIT} state_e;
  typedef enum logic [1:0] {SEL_NONE, SEL_LU, SEL_BR, SEL_BUSY} sel_e;

  state_e            r_state;
  state_e            w_next_state;
  sel_e              w_sel;
  logic              w_busy;
  logic              w_lu;
  logic              w_br;
  logic [WAIT_W-1:0] r_cur_wait;
  logic              r_mem_err;
  logic [CNT_W-1:0]  r_lu_cnt;
  logic [CNT_W-1:0]  r_fl_cnt;
  logic [CNT_W-1:0]  r_mw_cnt;

  assign w_busy = bus.MEM_req & ~bus.mem_ready;
  assign w_br   = bus.EX_PCSrc;
  assign w_lu   = bus.EX_MemRead && (bus.EX_RF_rd != 5'd0) &&
                  ((bus.ID_use_rs1 && (bus.ID_RF_rs1 == bus.EX_RF_rd)) ||
                   (bus.ID_use_rs2 && (bus.ID_RF_rs2 == bus.EX_RF_rd)));

  // A frozen pipeline outranks a redirect, which makes any load-use in ID moot.
  always_comb begin
    if (w_busy)    w_sel = SEL_BUSY;
    else if (w_br) w_sel = SEL_BR;
    else if (w_lu) w_sel = SEL_LU;
    else           w_sel = SEL_NONE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) r_state <= RUN;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      RUN:      if (w_busy)  w_next_state = MEM_WAIT;
      MEM_WAIT: if (!w_busy) w_next_state = RUN;
      default:  w_next_state = RUN;
    endcase
  end

  // NOTE: every output gets a default first so no path through the block
  // leaves a signal unassigned, which would infer a latch.
  always_comb begin
    bus.PC_stall    = 1'b0;
    bus.IFID_stall  = 1'b0;
    bus.IFID_flush  = 1'b0;
    bus.IDEX_stall  = 1'b0;
    bus.IDEX_flush  = 1'b0;
    bus.EXMEM_stall = 1'b0;
    bus.MEMWB_flush = 1'b0;
    if (!rst) begin
      unique case (w_sel)
        SEL_BUSY: begin
          bus.PC_stall    = 1'b1;
          bus.IFID_stall  = 1'b1;
          bus.IDEX_stall  = 1'b1;
          bus.EXMEM_stall = 1'b1;
          bus.MEMWB_flush = 1'b1;
        end
        SEL_BR: begin
          bus.IFID_flush = 1'b1;
          bus.IDEX_flush = 1'b1;
        end
        SEL_LU: begin
          bus.PC_stall   = 1'b1;
          bus.IFID_stall = 1'b1;
          bus.IDEX_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Watchdog: mem_err latches on the TIMEOUT-th consecutive busy cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_wait <= '0;
      r_mem_err  <= 1'b0;
    end else if (w_busy) begin
      if (r_cur_wait == WAIT_W'(TIMEOUT - 1)) r_mem_err  <= 1'b1;
      else                                    r_cur_wait <= r_cur_wait + 1'b1;
    end else begin
      r_cur_wait <= '0;
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lu_cnt <= '0;
      r_fl_cnt <= '0;
      r_mw_cnt <= '0;
    end else begin
      if ((w_sel == SEL_LU) && (r_lu_cnt != '1)) r_lu_cnt <= r_lu_cnt + 1'b1;
      if ((w_sel == SEL_BR) && (r_fl_cnt != '1)) r_fl_cnt <= r_fl_cnt + 1'b1;
      if (w_busy && (r_mw_cnt != '1))            r_mw_cnt <= r_mw_cnt + 1'b1;
    end
  end

  assign bus.mem_wait = (r_state == MEM_WAIT);
  assign bus.mem_err  = r_mem_err;
  assign bus.lu_cnt   = r_lu_cnt;
  assign bus.fl_cnt   = r_fl_cnt;
  assign bus.mw_cnt   = r_mw_cnt;

endmodule
